// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream and writes it to
// instruction memory as big-endian 32-bit words, holding the core in reset until the image verifies.
module imem_boot_loader #(
    parameter int unsigned MAX_WORDS = 256,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state;
    state_t      stateNext;

    logic [7:0]  lenHi;
    logic [15:0] wordCount;
    logic [15:0] wordIndex;
    logic [1:0]  byteCnt;
    logic [23:0] shiftReg;
    logic [7:0]  xorAcc;

    logic        accept;
    logic        wordDone;
    logic        lastWord;
    logic        lenTooBig;
    logic        lenZero;
    logic        chkMatch;
    logic        rearm;

    always_comb begin
        in_ready  = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                    (state == S_DATA)   || (state == S_CHECK);
        accept    = in_ready && in_valid;
        wordDone  = accept && (state == S_DATA) && (byteCnt == 2'd3);
        lastWord  = (wordIndex + 16'd1) == wordCount;
        lenTooBig = 32'({lenHi, in_data}) > MAX_WORDS;
        lenZero   = {lenHi, in_data} == 16'd0;
        chkMatch  = in_data == xorAcc;
        rearm     = restart && ((state == S_DONE) || (state == S_ERROR));

        stateNext = state;
        case (state)
            S_LEN_HI: if (accept) stateNext = S_LEN_LO;
            S_LEN_LO: begin
                if (accept) begin
                    if (lenTooBig)    stateNext = S_ERROR;
                    else if (lenZero) stateNext = S_CHECK;
                    else              stateNext = S_DATA;
                end
            end
            S_DATA:   if (wordDone && lastWord) stateNext = S_CHECK;
            S_CHECK:  if (accept) stateNext = chkMatch ? S_DONE : S_ERROR;
            S_DONE,
            S_ERROR:  if (restart) stateNext = S_LEN_HI;
            default:  stateNext = S_LEN_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= S_LEN_HI;
        else        state <= stateNext;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lenHi        <= '0;
            wordCount    <= '0;
            wordIndex    <= '0;
            byteCnt      <= '0;
            shiftReg     <= '0;
            xorAcc       <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            imem_we <= 1'b0;

            if (rearm) begin
                wordCount    <= '0;
                wordIndex    <= '0;
                byteCnt      <= '0;
                shiftReg     <= '0;
                xorAcc       <= '0;
                cpu_hold     <= 1'b1;
                done         <= 1'b0;
                error        <= 1'b0;
                words_loaded <= '0;
            end

            if (accept) begin
                case (state)
                    S_LEN_HI: lenHi <= in_data;
                    S_LEN_LO: begin
                        wordCount <= {lenHi, in_data};
                        if (lenTooBig) error <= 1'b1;
                    end
                    S_DATA: begin
                        shiftReg <= {shiftReg[15:0], in_data};
                        xorAcc   <= xorAcc ^ in_data;
                        byteCnt  <= byteCnt + 2'd1;
                        // Write strobe is registered: the word appears the cycle after its last byte.
                        if (byteCnt == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_wdata   <= {shiftReg, in_data};
                            imem_addr    <= ADDR_W'({wordIndex, 2'b00});
                            wordIndex    <= wordIndex + 16'd1;
                            words_loaded <= words_loaded + 16'd1;
                        end
                    end
                    S_CHECK: begin
                        if (chkMatch) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: table-driven frames, hand-written corner sequences,
// and randomized frames checked against a frame-level reference model.
module tb_imem_boot_loader;

    localparam int unsigned MAXW = 256;

    typedef logic [7:0]  byteq_t[$];
    typedef logic [63:0] wq_t[$];

    typedef struct packed {
        logic [127:0] stream;
        int unsigned  nBytes;
        logic         expDone;
        logic         expErr;
        logic [15:0]  expWords;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        restart = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int unsigned passed = 0;
    int unsigned total  = 0;
    wq_t         gotWrites;
    wq_t         lastWrites;
    logic        prevWe = 1'b0;
    int unsigned weWidthErr = 0;

    imem_boot_loader #(.MAX_WORDS(MAXW), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .restart(restart), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            gotWrites.push_back({imem_addr, imem_wdata});
            if (prevWe) weWidthErr++;
        end
        prevWe = imem_we;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else passed++;
    endtask

    function automatic void model(input byteq_t fr, output wq_t w, output logic eDone,
                                  output logic eErr, output logic [15:0] eWords);
        int unsigned n;
        logic [7:0]  chk;
        w = {};
        eDone = 1'b0;
        eErr = 1'b0;
        eWords = '0;
        n = fr[0] * 256 + fr[1];
        if (n > MAXW) begin
            eErr = 1'b1;
            return;
        end
        chk = 8'h00;
        for (int unsigned i = 0; i < n; i++) begin
            w.push_back({32'(i * 4), fr[2+4*i], fr[3+4*i], fr[4+4*i], fr[5+4*i]});
            for (int unsigned k = 0; k < 4; k++) chk = chk ^ fr[2+4*i+k];
        end
        eWords = 16'(n);
        if (fr[2+4*n] == chk) eDone = 1'b1;
        else eErr = 1'b1;
    endfunction

    task automatic sendByte(input logic [7:0] b, input int unsigned gap, input logic pulseRestart);
        int unsigned budget;
        in_valid = 1'b0;
        for (int unsigned g = 0; g < gap; g++) begin
            in_data = 8'($urandom);
            restart = pulseRestart && (g == 0);
            @(posedge clk);
            #1;
        end
        restart = 1'b0;
        in_valid = 1'b1;
        in_data = b;
        budget = 0;
        while (!in_ready && budget < 50) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("handshake_ready", {63'd0, in_ready}, 64'd1);
        if (in_ready) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // mode 0: back-to-back; 1: alternate idle cycles, 5-cycle gap + restart pulse mid-word; 2: random gaps
    task automatic sendFrame(input byteq_t fr, input int unsigned mode, input int unsigned count);
        int unsigned gap;
        for (int unsigned i = 0; i < count; i++) begin
            if (mode == 0) gap = 0;
            else if (mode == 1) gap = (i == 4) ? 5 : (i % 2);
            else gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            sendByte(fr[i], gap, (mode == 1) && (i == 4));
        end
    endtask

    task automatic doRestart(input string tag);
        @(posedge clk);
        #1 restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        check({tag, "_rst_ready"}, {63'd0, in_ready}, 64'd1);
        check({tag, "_rst_words"}, {48'd0, words_loaded}, 64'd0);
        check({tag, "_rst_flags"}, {61'd0, done, error, cpu_hold}, 64'd1);
    endtask

    task automatic runFrame(input byteq_t fr, input int unsigned mode, input string tag,
                            input logic eDone, input logic eErr, input logic [15:0] eWords);
        wq_t         mw;
        logic        mDone;
        logic        mErr;
        logic [15:0] mWords;
        int unsigned nSend;
        model(fr, mw, mDone, mErr, mWords);
        nSend = (fr[0] * 256 + fr[1] > MAXW) ? 2 : fr.size();
        gotWrites = {};
        weWidthErr = 0;
        sendFrame(fr, mode, nSend);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_done"}, {63'd0, done}, {63'd0, eDone});
        check({tag, "_error"}, {63'd0, error}, {63'd0, eErr});
        check({tag, "_cpu_hold"}, {63'd0, cpu_hold}, {63'd0, !eDone});
        check({tag, "_words"}, {48'd0, words_loaded}, {48'd0, eWords});
        check({tag, "_ready_low"}, {63'd0, in_ready}, 64'd0);
        check({tag, "_we_width"}, 64'(weWidthErr), 64'd0);
        check({tag, "_nwrites"}, 64'(gotWrites.size()), 64'(mw.size()));
        for (int unsigned i = 0; i < mw.size() && i < gotWrites.size(); i++)
            check($sformatf("%s_write%0d", tag, i), gotWrites[i], mw[i]);
        lastWrites = gotWrites;
    endtask

    function automatic byteq_t toQueue(input logic [127:0] s, input int unsigned n);
        byteq_t q;
        q = {};
        for (int unsigned k = 0; k < n; k++) q.push_back(s[127-8*k -: 8]);
        return q;
    endfunction

    initial begin
        vec_t        tbl[6];
        byteq_t      fr;
        byteq_t      s1;
        wq_t         mw;
        logic        mDone;
        logic        mErr;
        logic [15:0] mWords;
        int unsigned n;

        tbl[0] = '{128'h0002_2008_0005_0000_0000_2D00_0000_0000, 11, 1'b1, 1'b0, 16'd2};
        tbl[1] = '{128'h0002_2008_0005_0000_0000_2C00_0000_0000, 11, 1'b0, 1'b1, 16'd2};
        tbl[2] = '{128'h0101_0000_0000_0000_0000_0000_0000_0000, 2,  1'b0, 1'b1, 16'd0};
        tbl[3] = '{128'h0000_0000_0000_0000_0000_0000_0000_0000, 3,  1'b1, 1'b0, 16'd0};
        tbl[4] = '{128'h0000_0100_0000_0000_0000_0000_0000_0000, 3,  1'b0, 1'b1, 16'd0};
        tbl[5] = '{128'h0001_DEAD_BEEF_2200_0000_0000_0000_0000, 7,  1'b1, 1'b0, 16'd1};

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {imem_we, imem_addr, cpu_hold, done, error, in_ready, words_loaded},
              {1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0});
        reset = 1'b1;

        for (int unsigned t = 0; t < 6; t++) begin
            fr = toQueue(tbl[t].stream, tbl[t].nBytes);
            runFrame(fr, 0, $sformatf("tbl%0d", t), tbl[t].expDone, tbl[t].expErr, tbl[t].expWords);
            if (t == 0) begin
                check("s1_write0_const", lastWrites.size() > 0 ? lastWrites[0] : '0, 64'h00000000_20080005);
                check("s1_write1_const", lastWrites.size() > 1 ? lastWrites[1] : '0, 64'h00000004_00000000);
            end
            doRestart($sformatf("tbl%0d", t));
        end

        // Stalls, garbage data during gaps and an ignored restart mid-word
        s1 = toQueue(tbl[0].stream, 11);
        runFrame(s1, 1, "gaps", 1'b1, 1'b0, 16'd2);
        check("gaps_write1_const", lastWrites.size() > 1 ? lastWrites[1] : '0, 64'h00000004_00000000);
        doRestart("gaps");

        // Reset with the second word half-assembled
        gotWrites = {};
        sendFrame(s1, 0, 8);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_state", {imem_we, imem_addr, imem_wdata, cpu_hold, done, error, in_ready, words_loaded},
              {1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0});
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_nwrites", 64'(gotWrites.size()), 64'd1);
        runFrame(s1, 0, "midrst_reload", 1'b1, 1'b0, 16'd2);
        doRestart("midrst");

        for (int unsigned it = 0; it < 25; it++) begin
            if (it == 0) n = MAXW;
            else if (it == 1) n = MAXW + 1;
            else if (it == 2) n = $urandom_range(MAXW + 2, 65535);
            else n = $urandom_range(0, 6);
            fr = {};
            fr.push_back(8'(n >> 8));
            fr.push_back(8'(n));
            if (n <= MAXW) begin
                logic [7:0] c;
                c = 8'h00;
                for (int unsigned i = 0; i < 4 * n; i++) begin
                    fr.push_back(8'($urandom));
                    c = c ^ fr[fr.size()-1];
                end
                if ($urandom_range(0, 3) == 0) c = c ^ 8'(1 << $urandom_range(0, 7));
                fr.push_back(c);
            end
            model(fr, mw, mDone, mErr, mWords);
            runFrame(fr, 2, $sformatf("rnd%0d", it), mDone, mErr, mWords);
            doRestart($sformatf("rnd%0d", it));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
